// File: rtl/lcd_char_render_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_char_render_if : byte-write handshake between the rasteriser and the   |
// |                      ST7735 SPI byte writer.                               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface lcd_char_render_if;
  logic       spi_wr_req;
  logic [7:0] spi_wr_data;
  logic       spi_dc;
  logic       spi_wr_ack;

  modport master (output spi_wr_req, output spi_wr_data, output spi_dc, input  spi_wr_ack);
  modport slave  (input  spi_wr_req, input  spi_wr_data, input  spi_dc, output spi_wr_ack);
endinterface
`default_nettype wire

// File: rtl/lcd_char_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_char_render : renders CHAR_TOTAL font glyphs as ST7735 window commands |
// |                   followed by RGB565 pixel bytes.                          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lcd_char_render #(
  parameter int CHAR_TOTAL = 68,
  parameter int X_OFFSET   = 0,
  parameter int Y_OFFSET   = 0
) (
  input  wire logic         sys_clk,
  input  wire logic         sys_rst_n,
  input  wire logic         show_char_flag,
  input  wire logic         en_size,
  input  wire logic [6:0]   ascii_num,
  input  wire logic [8:0]   start_x,
  input  wire logic [8:0]   start_y,
  input  wire logic [15:0]  background_color,
  input  wire logic [15:0]  front_color,
  output logic [10:0]       font_addr,
  input  wire logic [7:0]   font_data,
  lcd_char_render_if.master spi,
  output logic              show_char_done,
  output logic              busy
);

  localparam int            CW         = (CHAR_TOTAL > 1) ? $clog2(CHAR_TOTAL) : 1;
  localparam logic [CW-1:0] LAST_GLYPH = CW'(CHAR_TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LATCH, S_CMD, S_FETCH, S_PIX, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          settle_q, settle_d;
  logic [CW-1:0] glyph_q, glyph_d;
  logic          size_q, size_d;
  logic [15:0]   front_q, front_d, back_q, back_d;
  logic [15:0]   xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [10:0]   base_q, base_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    pix_q, pix_d;
  logic          half_q, half_d;
  logic          fetch_wait_q, fetch_wait_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [10:0]   font_addr_q, font_addr_d;
  logic          req_q, req_d;
  logic [7:0]    data_q, data_d;
  logic          dc_q, dc_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [6:0]    asc;
  logic [15:0]   colour;
  logic [7:0]    cmd_byte;
  logic          cmd_dc;
  logic [2:0]    pix_last;
  logic [3:0]    row_last;

  always_comb begin
    asc      = (ascii_num > 7'd94) ? 7'd0 : ascii_num;
    colour   = shreg_q[7] ? front_q : back_q;
    pix_last = size_q ? 3'd7 : 3'd5;
    row_last = size_q ? 4'd15 : 4'd11;
    cmd_dc   = !((byte_idx_q == 4'd0) || (byte_idx_q == 4'd5) || (byte_idx_q == 4'd10));
    case (byte_idx_q)
      4'd0:    cmd_byte = 8'h2A;
      4'd1:    cmd_byte = xs_q[15:8];
      4'd2:    cmd_byte = xs_q[7:0];
      4'd3:    cmd_byte = xe_q[15:8];
      4'd4:    cmd_byte = xe_q[7:0];
      4'd5:    cmd_byte = 8'h2B;
      4'd6:    cmd_byte = ys_q[15:8];
      4'd7:    cmd_byte = ys_q[7:0];
      4'd8:    cmd_byte = ye_q[15:8];
      4'd9:    cmd_byte = ye_q[7:0];
      default: cmd_byte = 8'h2C;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    glyph_d      = glyph_q;
    size_d       = size_q;
    front_d      = front_q;
    back_d       = back_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    base_d       = base_q;
    byte_idx_d   = byte_idx_q;
    row_d        = row_q;
    pix_d        = pix_q;
    half_d       = half_q;
    fetch_wait_d = fetch_wait_q;
    shreg_d      = shreg_q;
    font_addr_d  = font_addr_q;
    req_d        = req_q;
    data_d       = data_q;
    dc_d         = dc_q;
    done_d       = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (show_char_flag) begin
          state_d  = S_SETTLE;
          settle_d = 1'b0;
          busy_d   = 1'b1;
          glyph_d  = '0;
        end
      end
      S_SETTLE: begin
        settle_d = ~settle_q;
        if (settle_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        size_d     = en_size;
        front_d    = front_color;
        back_d     = background_color;
        xs_d       = 16'(start_x) + 16'(X_OFFSET);
        xe_d       = xs_d + (en_size ? 16'd7 : 16'd5);
        ys_d       = 16'(start_y) + 16'(Y_OFFSET);
        ye_d       = ys_d + (en_size ? 16'd15 : 16'd11);
        // The 12x6 table starts after the 95 16x8 glyphs; high indices wrap in 11 bits.
        base_d     = en_size ? {asc, 4'b0000}
                             : 11'd1520 + {1'b0, asc, 3'b000} + {2'b00, asc, 2'b00};
        byte_idx_d = 4'd0;
        state_d    = S_CMD;
      end
      S_CMD: begin
        if (!req_q) begin
          req_d  = 1'b1;
          data_d = cmd_byte;
          dc_d   = cmd_dc;
        end else if (spi.spi_wr_ack) begin
          req_d = 1'b0;
          if (byte_idx_q == 4'd10) begin
            state_d      = S_FETCH;
            row_d        = 4'd0;
            font_addr_d  = base_q;
            fetch_wait_d = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      S_FETCH: begin
        // First cycle presents the address, second sees the ROM's registered row.
        fetch_wait_d = ~fetch_wait_q;
        if (fetch_wait_q) begin
          shreg_d = font_data;
          pix_d   = 3'd0;
          half_d  = 1'b0;
          state_d = S_PIX;
        end
      end
      S_PIX: begin
        if (!req_q) begin
          req_d  = 1'b1;
          dc_d   = 1'b1;
          data_d = half_q ? colour[7:0] : colour[15:8];
        end else if (spi.spi_wr_ack) begin
          req_d  = 1'b0;
          half_d = ~half_q;
          if (half_q) begin
            if (pix_q != pix_last) begin
              pix_d   = pix_q + 3'd1;
              shreg_d = {shreg_q[6:0], 1'b0};
            end else if (row_q != row_last) begin
              row_d        = row_q + 4'd1;
              font_addr_d  = base_q + 11'(row_q) + 11'd1;
              fetch_wait_d = 1'b0;
              state_d      = S_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        glyph_d = glyph_q + CW'(1);
        if (glyph_q == LAST_GLYPH) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      settle_q     <= 1'b0;
      glyph_q      <= '0;
      size_q       <= 1'b0;
      front_q      <= 16'd0;
      back_q       <= 16'd0;
      xs_q         <= 16'd0;
      xe_q         <= 16'd0;
      ys_q         <= 16'd0;
      ye_q         <= 16'd0;
      base_q       <= 11'd0;
      byte_idx_q   <= 4'd0;
      row_q        <= 4'd0;
      pix_q        <= 3'd0;
      half_q       <= 1'b0;
      fetch_wait_q <= 1'b0;
      shreg_q      <= 8'd0;
      font_addr_q  <= 11'd0;
      req_q        <= 1'b0;
      data_q       <= 8'd0;
      dc_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      glyph_q      <= glyph_d;
      size_q       <= size_d;
      front_q      <= front_d;
      back_q       <= back_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      base_q       <= base_d;
      byte_idx_q   <= byte_idx_d;
      row_q        <= row_d;
      pix_q        <= pix_d;
      half_q       <= half_d;
      fetch_wait_q <= fetch_wait_d;
      shreg_q      <= shreg_d;
      font_addr_q  <= font_addr_d;
      req_q        <= req_d;
      data_q       <= data_d;
      dc_q         <= dc_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign font_addr       = font_addr_q;
  assign spi.spi_wr_req  = req_q;
  assign spi.spi_wr_data = data_q;
  assign spi.spi_dc      = dc_q;
  assign show_char_done  = done_q;
  assign busy            = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_char_render : scoreboard bench for lcd_char_render with an upstream |
// |                      control model, font ROM model and SPI acker.          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_lcd_char_render;
  localparam int NG = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flag = 1'b0;
  logic        en_size, done, busy;
  logic [6:0]  ascii;
  logic [8:0]  sx, sy;
  logic [15:0] bg, fr;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  always #5 clk = ~clk;

  lcd_char_render_if sif ();

  lcd_char_render #(.CHAR_TOTAL(NG), .X_OFFSET(2), .Y_OFFSET(1)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .show_char_flag(flag), .en_size(en_size),
    .ascii_num(ascii), .start_x(sx), .start_y(sy), .background_color(bg),
    .front_color(fr), .font_addr(font_addr), .font_data(font_data), .spi(sif),
    .show_char_done(done), .busy(busy)
  );

  typedef struct packed {
    logic [6:0]  ascii;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        size;
    logic [15:0] fr;
    logic [15:0] bg;
    logic [63:0] win;   // xs, xe, ys, ye as big-endian 16-bit fields
    logic [10:0] base;
  } glyph_t;

  glyph_t gt [NG];
  logic [8:0] exp_q [$];

  int n_total = 0, n_pass = 0;
  int ack_delay = 0, popped = 0, dones = 0;
  int wait_cnt = 0, cd = 0, gidx = 0;
  logic in_byte = 1'b0, real_on = 1'b0, chk_busy_low = 1'b0;
  logic [8:0] held = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    if (a == 11'd528) return 8'hA5;
    return 8'(a * 11'd7) ^ 8'(a >> 3) ^ 8'h3C;
  endfunction

  always @(posedge clk) font_data <= rom_f(font_addr);

  function automatic int glyph_bytes(input int g);
    return gt[g].size ? 267 : 155;
  endfunction

  task automatic push_glyph(input int g);
    int w, h;
    logic [7:0]  row;
    logic [15:0] c;
    w = gt[g].size ? 8 : 6;
    h = gt[g].size ? 16 : 12;
    exp_q.push_back({1'b0, 8'h2A});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, gt[g].win[63-8*i -: 8]});
    exp_q.push_back({1'b0, 8'h2B});
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b1, gt[g].win[63-8*i -: 8]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int r = 0; r < h; r++) begin
      row = rom_f(gt[g].base + 11'(r));
      for (int b = 0; b < w; b++) begin
        c = row[7-b] ? gt[g].fr : gt[g].bg;
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endtask

  task automatic apply_glyph(input int g);
    ascii = gt[g].ascii; sx = gt[g].x; sy = gt[g].y; en_size = gt[g].size;
    fr = gt[g].fr; bg = gt[g].bg;
  endtask

  // Values the renderer must never capture: latching on the wrong cycle shows up as bad bytes.
  task automatic apply_garbage();
    ascii = 7'd5; sx = 9'd511; sy = 9'd511; en_size = ~en_size;
    fr = 16'h5555; bg = 16'hAAAA;
  endtask

  // SPI acker, scoreboard monitor and upstream control model share the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sif.spi_wr_ack = 1'b0;
      in_byte = 1'b0; cd = 0; real_on = 1'b0; chk_busy_low = 1'b0;
    end else begin
      if (sif.spi_wr_ack) begin
        sif.spi_wr_ack = 1'b0;
        check("req_low_after_ack", 32'(sif.spi_wr_req), 32'd0);
      end else if (sif.spi_wr_req) begin
        if (!in_byte) begin
          in_byte = 1'b1; held = {sif.spi_dc, sif.spi_wr_data}; wait_cnt = 0;
        end else begin
          check("byte_stable", 32'({sif.spi_dc, sif.spi_wr_data}), 32'(held));
        end
        if (wait_cnt >= ack_delay) begin
          sif.spi_wr_ack = 1'b1;
          in_byte = 1'b0;
          check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            check($sformatf("byte%0d", popped), 32'({sif.spi_dc, sif.spi_wr_data}),
                  32'(exp_q.pop_front()));
            popped++;
          end
        end else begin
          wait_cnt++;
        end
      end

      if (chk_busy_low) begin
        check("busy_low_after_last", 32'(busy), 32'd0);
        chk_busy_low = 1'b0;
      end
      if (done) begin
        int rem;
        dones++;
        gidx++;
        rem = 0;
        for (int g = gidx; g < NG; g++) rem += glyph_bytes(g);
        check($sformatf("bytes_left_at_done%0d", dones), 32'(exp_q.size()), 32'(rem));
        if (gidx == NG) chk_busy_low = 1'b1;
        cd = 3; real_on = 1'b0;
        apply_garbage();
      end else if (flag && !busy) begin
        gidx = 0; cd = 3; real_on = 1'b0;
        apply_garbage();
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && gidx < NG) begin
          apply_glyph(gidx);
          real_on = 1'b1;
        end
      end else if (real_on) begin
        apply_garbage();
        real_on = 1'b0;
      end
    end
  end

  task automatic start_run();
    @(posedge clk); #1 flag = 1'b1;
    @(posedge clk); #1 flag = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    check({name, "_finished"}, 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 32'(dones), NG);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_all();
    for (int g = 0; g < NG; g++) push_glyph(g);
  endtask

  initial begin
    gt[0] = '{ascii: 7'd33, x: 9'd46, y: 9'd0, size: 1'b1, fr: 16'hFFFF, bg: 16'hAF7D,
              win: 64'h0030_0037_0001_0010, base: 11'd528};
    gt[1] = '{ascii: 7'd16, x: 9'd10, y: 9'd20, size: 1'b0, fr: 16'hF81F, bg: 16'h0841,
              win: 64'h000C_0011_0015_0020, base: 11'd1712};
    gt[2] = '{ascii: 7'd120, x: 9'd300, y: 9'd150, size: 1'b1, fr: 16'hF800, bg: 16'h07E0,
              win: 64'h012E_0135_0097_00A6, base: 11'd0};
    en_size = 1'b0; ascii = '0; sx = '0; sy = '0; bg = '0; fr = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_req",   32'(sif.spi_wr_req),  32'd0);
    check("rst_data",  32'(sif.spi_wr_data), 32'd0);
    check("rst_dc",    32'(sif.spi_dc),      32'd0);
    check("rst_done",  32'(done),            32'd0);
    check("rst_busy",  32'(busy),            32'd0);
    check("rst_faddr", 32'(font_addr),       32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Instant ack
    ack_delay = 0; dones = 0;
    push_all();
    start_run();
    wait_idle("instant");

    // Slow ack plus an ignored start pulse while busy
    ack_delay = 5; dones = 0;
    push_all();
    start_run();
    repeat (300) @(posedge clk);
    #1 flag = 1'b1;
    @(posedge clk); #1 flag = 1'b0;
    wait_idle("slow");

    // Reset in the middle of the first glyph's pixels
    ack_delay = 2; dones = 0;
    push_all();
    begin
      int target;
      target = popped + 60;
      start_run();
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk);
        if (popped >= target) break;
      end
      check("reached_pix", 32'(popped >= target), 32'd1);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_req",  32'(sif.spi_wr_req), 32'd0);
    check("midrst_data", 32'(sif.spi_wr_data), 32'd0);
    check("midrst_dc",   32'(sif.spi_dc), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(dones), 32'd0);

    ack_delay = 0; dones = 0;
    push_all();
    start_run();
    wait_idle("restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lcd_char_render.md
Name: lcd_char_render

Overview:
- Character rasteriser between the string/number control stage and the SPI byte writer of the ST7735 path.
- On a start pulse it renders CHAR_TOTAL glyphs back-to-back. Per glyph it latches ascii_num, position, colours and size from the control stage.
- For each glyph it emits the ST7735 window commands (CASET/RASET/RAMWR), then RGB565 pixels from the font ROM, then pulses show_char_done so the control stage advances.

Parameters:
CHAR_TOTAL, 68, number of glyphs rendered per show_char_flag
X_OFFSET, 0, panel column offset added to CASET coordinates
Y_OFFSET, 0, panel row offset added to RASET coordinates

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
show_char_flag  in  1  one-cycle start pulse
en_size  in  1  1: 16x8 glyph, 0: 12x6 glyph
ascii_num  in  7  font index (ASCII-32), valid 0..94
start_x  in  9  glyph left column
start_y  in  9  glyph top row
background_color  in  16  RGB565 for 0 bits
front_color  in  16  RGB565 for 1 bits
font_addr  out  11  font ROM row address
font_data  in  8  font ROM row, 1-cycle synchronous latency, bit7 = leftmost pixel
spi_wr_req  out  1  byte write request
spi_wr_data  out  8  byte to send
spi_dc  out  1  0 = command, 1 = data
spi_wr_ack  in  1  one-cycle pulse: byte accepted
show_char_done  out  1  one-cycle pulse per finished glyph
busy  out  1  high from accepted start to end of last glyph

Behaviour:
- Reset (async, any state) forces: state IDLE; all outputs 0; glyph counter 0.
- Clock and reset: sys_clk only; sys_rst_n asynchronous active-low.
- Glyph geometry: W=8, H=16 if en_size=1; W=6, H=12 if en_size=0. Geometry is latched per glyph.
- font_addr rules:
  - 16x8: ascii*16+row.
  - 12x6: 1520+ascii*12+row; only bits 7..2 are used.
  - ascii_num>94 is latched as 0 (space).
- States:
  - IDLE: busy=0. show_char_flag goes to SETTLE, sets busy=1, clears the glyph counter.
  - SETTLE: exactly 2 cycles, lets the upstream registers update, then goes to LATCH.
  - LATCH: 1 cycle. Captures ascii_num, start_x, start_y, both colours and en_size. Computes xs=start_x+X_OFFSET, xe=xs+W-1, ys=start_y+Y_OFFSET, ye=ys+H-1 as 16-bit values with no clipping. Goes to CMD.
  - CMD: sends 11 bytes in order: 0x2A(c), xs[15:8], xs[7:0], xe[15:8], xe[7:0], 0x2B(c), ys hi, ys lo, ye hi, ye lo, 0x2C(c). (c) bytes use dc=0; all others dc=1. Then goes to FETCH with row=0.
  - FETCH: presents font_addr, waits 1 cycle, captures font_data into a shift register, goes to PIX.
  - PIX: sends W pixels, bit7 first. Each pixel is colour[15:8] then colour[7:0], dc=1. After the last pixel of a row: row<H-1 goes to FETCH with row+1; otherwise goes to DONE.
  - DONE: show_char_done=1 for exactly 1 cycle. Glyph counter increments. If the counter was CHAR_TOTAL-1, go to IDLE with busy=0; otherwise go to SETTLE.
- Byte handshake:
  - spi_wr_req rises with spi_wr_data/spi_dc stable and holds until the spi_wr_ack cycle.
  - req is 0 the cycle after ack.
  - The next byte's req may rise no earlier than 1 cycle after that.
  - An ack without req is ignored.
- Bytes per glyph: 11+2*W*H, i.e. 267 for 16x8 and 155 for 12x6.
- show_char_flag while busy is ignored. spi_wr_ack stalls of any length are tolerated; the state holds.
- Deasserting reset mid-glyph restarts only on the next show_char_flag.

Test Plan:
- Start with ascii_num=33 ('A'), start_x=48, start_y=0, en_size=1, instant ack -> bytes: 2A,00,30,00,37,2B,00,00,00,0F,2C, then 256 pixel bytes. font_addr steps 528..543. Exactly one show_char_done.
- en_size=0, start_x=10, start_y=20, X_OFFSET=2, Y_OFFSET=1 -> CASET 00,0C,00,11; RASET 00,15,00,20. font_addr begins at 1520+ascii*12. 155 bytes total.
- font row 0xA5, front=FFFF, bg=AF7D -> pixel bytes FF,FF,AF,7D,FF,FF,AF,7D,AF,7D,FF,FF,AF,7D,FF,FF.
- Ack delayed 5 cycles per byte -> data/dc stable while req is high. Byte sequence is identical to the instant-ack case. No byte is lost or duplicated.
- CHAR_TOTAL=3 with upstream model -> 3 done pulses. Inputs are latched 3 cycles after each done. busy falls after the 3rd. A second show_char_flag mid-run is ignored.
- Reset asserted mid-PIX -> outputs 0 immediately. No activity until a new show_char_flag, which restarts from glyph 0.
